lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit sitting directly upstream of the dcache in the memory-access pipeline stage.
- Accepts one memory micro-op at a time from the execute stage and checks alignment.
- Drives the dcache request interface (valid/op/addr/w_data_CPU/write_type) and waits for data_valid.
- Aligns and extends load data, then presents a single writeback result with an exception code to the next stage.

Parameters:
- ALE_CODE, 7'h09, exception code reported for misaligned access.
- TIMEOUT, 256, cycles before watchdog fires; used only when LSU_TIMEOUT_EN is defined.
- TMO_CODE, 7'h0A, exception code reported on watchdog timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  micro-op valid from execute
- req_ready  out  1  LSU can accept a micro-op
- req_op  in  1  0=load, 1=store
- req_size  in  2  0=byte, 1=half, 2=word; 3 is illegal and treated as word
- req_unsigned  in  1  zero-extend load when 1
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_rd  in  5  destination register tag
- dc_valid  out  1  request to dcache
- dc_op  out  1  0=read, 1=write
- dc_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dc_w_data  out  32  lane-replicated store data
- dc_write_type  out  4  byte strobe
- dc_data_valid  in  1  dcache completion
- dc_r_data  in  32  dcache read word
- dc_exp  in  7  dcache exception, 0 = none
- wb_valid  out  1  result valid, one-cycle pulse
- wb_data  out  32  extended load data; 0 for stores
- wb_rd  out  5  register tag
- wb_exp  out  7  exception code, 0 = none

Behaviour:
- Reset values: req_ready=1; dc_valid=0; dc_op=0; dc_addr=0; dc_w_data=0; dc_write_type=0; wb_valid=0; wb_data=0; wb_rd=0; wb_exp=0; state=IDLE. Reset mid-transaction abandons the request without completing it.
- FSM states: IDLE, WAIT, DONE.
- IDLE (req_ready=1): on req_valid, capture all request fields.
  - Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - If misaligned: go to DONE with wb_exp=ALE_CODE; no dcache request is issued.
  - Otherwise: go to WAIT and assert dc_valid on the next cycle.
- WAIT (req_ready=0): dc_valid held 1 with dc_addr/dc_op/dc_w_data/dc_write_type stable until the cycle dc_data_valid=1. dc_valid drops the following cycle, then go to DONE.
  - Capture dc_r_data and dc_exp on the dc_data_valid cycle.
  - dc_data_valid seen in IDLE or DONE is ignored.
- DONE: wb_valid=1 for exactly one cycle, then IDLE. req_ready rises the cycle after DONE.
  - Minimum latency: accept to wb_valid = 2 cycles plus dcache latency. A misaligned request reaches wb_valid 1 cycle after accept.
- Strobe by size:
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1]?4'b1100:4'b0011
  - word: 4'b1111
  - Loads also drive this strobe on dc_write_type.
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction:
  - byte: r_data >> (8*addr[1:0]), take the low 8 bits.
  - half: take the upper half when addr[1]=1, otherwise the lower half.
  - Sign-extend unless req_unsigned=1.
- wb_exp=dc_exp when it is nonzero; wb_data is then 0.
- Stores: wb_data=0. wb_rd still reflects the captured tag; downstream ignores it for stores.
- Only one outstanding request at a time; no pipelining.

Optional Feature:
- LSU_TIMEOUT_EN:
  - When defined: a counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 without dc_data_valid: dc_valid drops, go to DONE with wb_exp=TMO_CODE and wb_data=0.
  - A late dc_data_valid is ignored.
- Without the macro: WAIT persists indefinitely and no counter logic exists.

Test Plan:
- Load byte, addr=0x1003, size=0, unsigned=0, dc_r_data=0x80AABBCC -> dc_addr=0x1000, dc_write_type=4'b1000, wb_data=0xFFFFFF80, wb_exp=0.
- Load half unsigned, addr=0x2002, dc_r_data=0x9234_5678 -> wb_data=0x00009234. Same access with signed -> wb_data=0xFFFF9234.
- Store byte, addr=0x3001, wdata=0x000000A5 -> dc_op=1, dc_w_data=0xA5A5A5A5, dc_write_type=4'b0010; wb_valid pulses once with wb_data=0.
- Word load at addr=0x4002 -> dc_valid never asserts; wb_valid one cycle after accept with wb_exp=7'h09.
- dcache returns dc_exp=7'h03 on a word load after 5 wait cycles -> wb_exp=7'h03, wb_data=0. req_ready stays 0 during WAIT and a held req_valid is not accepted until IDLE.
- With LSU_TIMEOUT_EN and TIMEOUT=8, dc_data_valid never returned -> wb_exp=7'h0A. Assert rst mid-WAIT -> next cycle dc_valid=0, req_ready=1, wb_valid=0.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit in front of the dcache in the memory stage.
// It takes one micro-op at a time, checks alignment, runs a single dcache
// transaction, then aligns and extends the load data for writeback.
// The optional watchdog on the dcache wait is built only when LSU_TIMEOUT_EN
// is defined.
module lsu_mem_stage #(
    parameter logic [6:0] ALE_CODE = 7'h09,
    parameter int         TIMEOUT  = 256,
    parameter logic [6:0] TMO_CODE = 7'h0A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        dc_valid,
    output logic        dc_op,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_w_data,
    output logic [3:0]  dc_write_type,
    input  logic        dc_data_valid,
    input  logic [31:0] dc_r_data,
    input  logic [6:0]  dc_exp,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic [6:0]  wb_exp
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    // Size 3 is illegal and is folded onto word before anything uses it.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t     state, next_state;
    logic [1:0] size_n;
    logic       misaligned;
    logic [1:0] addr_lo;
    logic [1:0] size_q;
    logic       unsigned_q;
    logic       timeout_hit;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] wait_cnt;
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign size_n     = (req_size == 2'd3) ? SZ_WORD : req_size;
    assign misaligned = ((size_n == SZ_HALF) && req_addr[0]) ||
                        ((size_n == SZ_WORD) && (req_addr[1:0] != 2'b00));

    assign req_ready = (state == IDLE);
    assign dc_valid  = (state == WAIT);
    assign wb_valid  = (state == DONE);

    // Right-justify the addressed lane of the read word and extend it.
    function automatic logic [31:0] extract(input logic [31:0] r, input logic [1:0] lo,
                                            input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(r >> {lo, 3'b000});
        h = lo[1] ? r[31:16] : r[15:0];
        case (sz)
            SZ_BYTE: extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: extract = r;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = misaligned ? DONE : WAIT;
            WAIT:    if (dc_data_valid || timeout_hit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request capture, dcache request fields and writeback result.
    always_ff @(posedge clk) begin
        if (rst) begin
            dc_op         <= 1'b0;
            dc_addr       <= '0;
            dc_w_data     <= '0;
            dc_write_type <= '0;
            addr_lo       <= '0;
            size_q        <= '0;
            unsigned_q    <= 1'b0;
            wb_data       <= '0;
            wb_rd         <= '0;
            wb_exp        <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    dc_op      <= req_op;
                    dc_addr    <= {req_addr[31:2], 2'b00};
                    addr_lo    <= req_addr[1:0];
                    size_q     <= size_n;
                    unsigned_q <= req_unsigned;
                    wb_rd      <= req_rd;
                    wb_data    <= '0;
                    wb_exp     <= misaligned ? ALE_CODE : 7'd0;
                    case (size_n)
                        SZ_BYTE: begin
                            dc_w_data     <= {4{req_wdata[7:0]}};
                            dc_write_type <= 4'b0001 << req_addr[1:0];
                        end
                        SZ_HALF: begin
                            dc_w_data     <= {2{req_wdata[15:0]}};
                            dc_write_type <= req_addr[1] ? 4'b1100 : 4'b0011;
                        end
                        default: begin
                            dc_w_data     <= req_wdata;
                            dc_write_type <= 4'b1111;
                        end
                    endcase
                end
                WAIT: if (dc_data_valid) begin
                    wb_exp  <= dc_exp;
                    wb_data <= ((dc_exp != 7'd0) || dc_op) ? 32'd0
                             : extract(dc_r_data, addr_lo, size_q, unsigned_q);
                end else if (timeout_hit) begin
                    wb_exp  <= TMO_CODE;
                    wb_data <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_TIMEOUT_EN
    // Watchdog: cleared while idle so it starts at zero on entry to WAIT.
    always_ff @(posedge clk) begin
        if (rst)                 wait_cnt <= '0;
        else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
        else                     wait_cnt <= '0;
    end
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: inputs driven and outputs sampled on the
// falling clock edge; expected values are hand-computed constants.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_op, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        dc_valid, dc_op, dc_data_valid;
    logic [31:0] dc_addr, dc_w_data, dc_r_data;
    logic [3:0]  dc_write_type;
    logic [6:0]  dc_exp;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic [6:0]  wb_exp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .dc_valid(dc_valid), .dc_op(dc_op), .dc_addr(dc_addr), .dc_w_data(dc_w_data),
        .dc_write_type(dc_write_type), .dc_data_valid(dc_data_valid),
        .dc_r_data(dc_r_data), .dc_exp(dc_exp),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_exp(wb_exp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns at the next falling edge.
    task automatic issue(input logic op, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        req_valid = 1'b1; req_op = op; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Complete the dcache access for one cycle; returns at the next falling edge.
    task automatic respond(input logic [31:0] rdata, input logic [6:0] exp);
        dc_data_valid = 1'b1; dc_r_data = rdata; dc_exp = exp;
        @(negedge clk);
        dc_data_valid = 1'b0; dc_exp = 7'd0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        dc_data_valid = 1'b0; dc_r_data = '0; dc_exp = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_req_ready", req_ready, 1);
        check("rst_dc_valid", dc_valid, 0);
        check("rst_dc_addr", dc_addr, 0);
        check("rst_dc_write_type", dc_write_type, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_exp", wb_exp, 0);
        rst = 1'b0;
        @(negedge clk);

        // Signed byte load from lane 3
        issue(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 5'd5);
        check("lb_dc_valid", dc_valid, 1);
        check("lb_dc_op", dc_op, 0);
        check("lb_dc_addr", dc_addr, 32'h0000_1000);
        check("lb_strobe", dc_write_type, 4'b1000);
        check("lb_req_ready", req_ready, 0);
        respond(32'h80AA_BBCC, 7'd0);
        check("lb_dc_valid_drop", dc_valid, 0);
        check("lb_wb_valid", wb_valid, 1);
        check("lb_wb_data", wb_data, 32'hFFFF_FF80);
        check("lb_wb_exp", wb_exp, 0);
        check("lb_wb_rd", wb_rd, 5);
        @(negedge clk);
        check("lb_wb_pulse", wb_valid, 0);
        check("lb_ready_back", req_ready, 1);

        // Half load from upper half, unsigned then signed
        issue(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 5'd6);
        check("lhu_strobe", dc_write_type, 4'b1100);
        respond(32'h9234_5678, 7'd0);
        check("lhu_wb_data", wb_data, 32'h0000_9234);
        @(negedge clk);
        issue(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 5'd6);
        respond(32'h9234_5678, 7'd0);
        check("lh_wb_data", wb_data, 32'hFFFF_9234);
        @(negedge clk);

        // Byte store to lane 1
        issue(1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'h0000_00A5, 5'd7);
        check("sb_dc_op", dc_op, 1);
        check("sb_dc_w_data", dc_w_data, 32'hA5A5_A5A5);
        check("sb_strobe", dc_write_type, 4'b0010);
        respond(32'hFFFF_FFFF, 7'd0);
        check("sb_wb_valid", wb_valid, 1);
        check("sb_wb_data", wb_data, 0);
        @(negedge clk);
        check("sb_wb_once", wb_valid, 0);

        // Half store to upper half
        issue(1'b1, 2'd1, 1'b0, 32'h0000_8002, 32'h1234_BEEF, 5'd8);
        check("sh_dc_w_data", dc_w_data, 32'hBEEF_BEEF);
        check("sh_strobe", dc_write_type, 4'b1100);
        respond(32'h0, 7'd0);
        @(negedge clk);

        // Misaligned word load: no dcache request, result one cycle after accept
        issue(1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'h0, 5'd9);
        check("ale_dc_valid", dc_valid, 0);
        check("ale_wb_valid", wb_valid, 1);
        check("ale_wb_exp", wb_exp, 7'h09);
        check("ale_wb_data", wb_data, 0);
        @(negedge clk);
        check("ale_wb_pulse", wb_valid, 0);
        check("ale_ready", req_ready, 1);

        // Misaligned half load
        issue(1'b0, 2'd1, 1'b0, 32'h0000_8001, 32'h0, 5'd9);
        check("ale_h_dc_valid", dc_valid, 0);
        check("ale_h_wb_exp", wb_exp, 7'h09);
        @(negedge clk);

        // Illegal size 3 behaves as word: aligned passes, misaligned traps
        issue(1'b0, 2'd3, 1'b1, 32'h0000_7000, 32'h0, 5'd10);
        check("sz3_strobe", dc_write_type, 4'b1111);
        respond(32'h8765_4321, 7'd0);
        check("sz3_wb_data", wb_data, 32'h8765_4321);
        @(negedge clk);
        issue(1'b0, 2'd3, 1'b0, 32'h0000_7001, 32'h0, 5'd10);
        check("sz3_ale", wb_exp, 7'h09);
        @(negedge clk);

        // dcache exception after 5 wait cycles, with a second request held on req_valid
        req_valid = 1'b1; req_op = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0000_5000; req_rd = 5'd11;
        @(negedge clk);
        req_addr = 32'h0000_6000; req_rd = 5'd12;
        for (int i = 0; i < 5; i++) begin
            check("hold_req_ready", req_ready, 0);
            check("hold_dc_addr", dc_addr, 32'h0000_5000);
            @(negedge clk);
        end
        check("exp_dc_valid_held", dc_valid, 1);
        respond(32'hDEAD_BEEF, 7'h03);
        check("exp_wb_exp", wb_exp, 7'h03);
        check("exp_wb_data", wb_data, 0);
        check("exp_wb_rd", wb_rd, 11);
        @(negedge clk);
        check("held_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("held_dc_valid", dc_valid, 1);
        check("held_dc_addr", dc_addr, 32'h0000_6000);
        respond(32'h1122_3344, 7'd0);
        check("held_wb_data", wb_data, 32'h1122_3344);
        check("held_wb_exp", wb_exp, 0);
        @(negedge clk);

`ifdef LSU_TIMEOUT_EN
        // Watchdog: no completion, eight WAIT cycles then TMO result
        begin
            int wait_cycles = 0;
            issue(1'b0, 2'd2, 1'b0, 32'h0000_9000, 32'h0, 5'd13);
            while (dc_valid === 1'b1 && wait_cycles < 40) begin
                wait_cycles++;
                @(negedge clk);
            end
            check("tmo_wait_cycles", wait_cycles, 8);
            check("tmo_wb_valid", wb_valid, 1);
            check("tmo_wb_exp", wb_exp, 7'h0A);
            check("tmo_wb_data", wb_data, 0);
            respond(32'h5555_5555, 7'd0);
            check("tmo_late_ignored", dc_valid | wb_valid, 0);
            @(negedge clk);
        end
`endif

        // Reset in the middle of WAIT abandons the request
        issue(1'b0, 2'd2, 1'b0, 32'h0000_A000, 32'h0, 5'd14);
        check("rw_dc_valid", dc_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rw_dc_valid_clr", dc_valid, 0);
        check("rw_req_ready", req_ready, 1);
        check("rw_wb_valid", wb_valid, 0);

        // Completion strobe while idle is ignored
        respond(32'h7777_7777, 7'h03);
        check("idle_dv_wb_valid", wb_valid, 0);
        check("idle_dv_ready", req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog on the whole run.
    initial begin
        #200000;
        $display("FAIL run_timeout observed=running expected=finished");
        $fatal(1, "run timeout");
    end

endmodule
